// File: rtl/dispatch_pkg.sv
// Shared types for the dual-core instruction dispatch scheduler.
package dispatch_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    HELD     = 2'd1,
    DRAINING = 2'd2,
    DRAINED  = 2'd3
  } state_t;

  localparam logic CORE1 = 1'b0;
  localparam logic CORE2 = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency 1 cycle from inc to count; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/instr_dispatch_sched.sv
// Round-robin dispatch of one staged instruction to two core FIFOs; 1 cycle accept->write.
// Skips a full FIFO, stalls intake when both are full; DISPATCH_STATS_EN adds counters.
module instr_dispatch_sched #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fifo1_full,
  input  logic              fifo2_full,
  output logic              fifo1_wr,
  output logic              fifo2_wr,
  output logic [DATA_W-1:0] fifo1_data,
  output logic [DATA_W-1:0] fifo2_data,
  input  logic              drain,
  output logic              drain_done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  disp_cnt1,
  output logic [CNT_W-1:0]  disp_cnt2,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  import dispatch_pkg::*;

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] hold;
  logic              hold_v;
  logic              hold_nxt_v;
  logic              sel;
  logic              disp1;
  logic              disp2;
  logic              xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Dispatch happens first; a freed staging slot can be refilled in the same cycle.
  always_comb begin
    hold_v     = (state == HELD) || (state == DRAINING);
    disp1      = hold_v && (((sel == CORE1) && !fifo1_full) ||
                            ((sel == CORE2) && fifo2_full && !fifo1_full));
    disp2      = hold_v && (((sel == CORE2) && !fifo2_full) ||
                            ((sel == CORE1) && fifo1_full && !fifo2_full));
    in_ready   = !drain && (!hold_v || disp1 || disp2);
    xfer       = in_valid && in_ready;
    hold_nxt_v = xfer || (hold_v && !(disp1 || disp2));
    drain_done = (state == DRAINED);
    state_nxt  = state;
    if (drain) begin
      state_nxt = hold_nxt_v ? DRAINING : DRAINED;
    end else begin
      state_nxt = hold_nxt_v ? HELD : EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      sel  <= CORE1;
    end else begin
      if (xfer) begin
        hold <= in_instr;
      end
      if (disp1) begin
        sel <= CORE2;
      end else if (disp2) begin
        sel <= CORE1;
      end
    end
  end

  assign fifo1_wr   = disp1;
  assign fifo2_wr   = disp2;
  assign fifo1_data = hold;
  assign fifo2_data = hold;

`ifdef DISPATCH_STATS_EN
  sat_counter #(.W(CNT_W)) u_disp_cnt1 (
    .clk (clk),
    .clr (reset),
    .inc (disp1),
    .cnt (disp_cnt1)
  );

  sat_counter #(.W(CNT_W)) u_disp_cnt2 (
    .clk (clk),
    .clr (reset),
    .inc (disp2),
    .cnt (disp_cnt2)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (hold_v && fifo1_full && fifo2_full),
    .cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_instr_dispatch_sched.sv
// Directed bench for instr_dispatch_sched with a queue-based reference model.
module tb_instr_dispatch_sched;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_instr;
  logic              in_valid;
  logic              in_ready;
  logic              fifo1_full;
  logic              fifo2_full;
  logic              fifo1_wr;
  logic              fifo2_wr;
  logic [DATA_W-1:0] fifo1_data;
  logic [DATA_W-1:0] fifo2_data;
  logic              drain;
  logic              drain_done;
`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0]  disp_cnt1;
  logic [CNT_W-1:0]  disp_cnt2;
  logic [CNT_W-1:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_dispatch_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_instr   (in_instr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fifo1_full (fifo1_full),
    .fifo2_full (fifo2_full),
    .fifo1_wr   (fifo1_wr),
    .fifo2_wr   (fifo2_wr),
    .fifo1_data (fifo1_data),
    .fifo2_data (fifo2_data),
    .drain      (drain),
    .drain_done (drain_done)
`ifdef DISPATCH_STATS_EN
    ,
    .disp_cnt1  (disp_cnt1),
    .disp_cnt2  (disp_cnt2),
    .stall_cnt  (stall_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit started = 1'b0;

  // Reference model: pending instructions in order, preferred core, drained flag.
  logic [DATA_W-1:0] m_held[$];
  int                m_pref;
  bit                m_drained;
  logic [DATA_W-1:0] m_last;
  int                m_c1, m_c2, m_st;

  logic [DATA_W-1:0] got1[$];
  logic [DATA_W-1:0] got2[$];
  int                wcyc[$];
  int                acyc[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int m_target();
    if (m_held.size() == 0) return 0;
    if (m_pref == 1) begin
      if (!fifo1_full) return 1;
      if (!fifo2_full) return 2;
    end else begin
      if (!fifo2_full) return 2;
      if (!fifo1_full) return 1;
    end
    return 0;
  endfunction

  function automatic bit m_ready();
    return !drain && ((m_held.size() == 0) || (m_target() != 0));
  endfunction

  always @(posedge clk) begin : model
    int t;
    bit acc;
    bit stall;
    cyc++;
    if (reset) begin
      m_held.delete();
      m_pref    = 1;
      m_drained = 1'b0;
      m_last    = '0;
      m_c1      = 0;
      m_c2      = 0;
      m_st      = 0;
      started   = 1'b1;
    end else begin
      t     = m_target();
      acc   = m_ready() && in_valid;
      stall = (m_held.size() != 0) && fifo1_full && fifo2_full;
      if (stall && m_st < CMAX) m_st++;
      if (t == 1 && m_c1 < CMAX) m_c1++;
      if (t == 2 && m_c2 < CMAX) m_c2++;
      if (t != 0) begin
        void'(m_held.pop_front());
        m_pref = (t == 1) ? 2 : 1;
      end
      if (acc) begin
        m_held.push_back(in_instr);
        m_last = in_instr;
      end
      m_drained = drain && (m_held.size() == 0);
    end
  end

  always @(negedge clk) begin : compare
    int t;
    if (started) begin
      t = m_target();
      chk("in_ready", in_ready, m_ready());
      chk("fifo1_wr", fifo1_wr, t == 1);
      chk("fifo2_wr", fifo2_wr, t == 2);
      chk("fifo1_data", fifo1_data, m_last);
      chk("fifo2_data", fifo2_data, m_last);
      chk("drain_done", drain_done, m_drained);
`ifdef DISPATCH_STATS_EN
      chk("disp_cnt1", disp_cnt1, m_c1);
      chk("disp_cnt2", disp_cnt2, m_c2);
      chk("stall_cnt", stall_cnt, m_st);
`endif
      if (fifo1_wr) begin got1.push_back(fifo1_data); wcyc.push_back(cyc); end
      if (fifo2_wr) begin got2.push_back(fifo2_data); wcyc.push_back(cyc); end
      if (in_valid && in_ready) acyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got1.delete();
    got2.delete();
    wcyc.delete();
    acyc.delete();
  endtask

  task automatic send(input logic [DATA_W-1:0] v);
    in_valid = 1'b1;
    in_instr = v;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    in_instr   = '0;
    in_valid   = 1'b0;
    fifo1_full = 1'b0;
    fifo2_full = 1'b0;
    drain      = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr1", fifo1_wr, 0);
    chk("rst_wr2", fifo2_wr, 0);
    chk("rst_data1", fifo1_data, 0);
    chk("rst_drain_done", drain_done, 0);

    // Alternating stream with both FIFOs free.
    clear_logs();
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    in_valid = 1'b0;
    step(); step();
    chk("rr_f1_n", got1.size(), 2);
    chk("rr_f1_0", got1[0], 32'h11);
    chk("rr_f1_1", got1[1], 32'h33);
    chk("rr_f2_n", got2.size(), 2);
    chk("rr_f2_0", got2[0], 32'h22);
    chk("rr_f2_1", got2[1], 32'h44);
    chk("rr_first_lat", wcyc[0] - acyc[0], 1);
    chk("rr_back2back", wcyc[3] - wcyc[0], 3);

    // Preferred FIFO1 full: skip to FIFO2, then next goes to FIFO1.
    clear_logs();
    fifo1_full = 1'b1;
    send(32'hAA);
    in_instr = 32'hBB;
    step();
    in_valid   = 1'b0;
    fifo1_full = 1'b0;
    step(); step();
    chk("skip_f2_n", got2.size(), 1);
    chk("skip_f2_0", got2[0], 32'hAA);
    chk("skip_f1_n", got1.size(), 1);
    chk("skip_f1_0", got1[0], 32'hBB);

    // Both full for 5 cycles with 0xCC held.
    clear_logs();
    fifo1_full = 1'b1;
    fifo2_full = 1'b1;
    send(32'hCC);
    in_valid = 1'b0;
    repeat (5) step();
    chk("stall_in_ready", in_ready, 0);
    chk("stall_no_writes", got1.size() + got2.size(), 0);
`ifdef DISPATCH_STATS_EN
    chk("stall_cnt_5", stall_cnt, 5);
`endif
    fifo2_full = 1'b0;
    step(); step(); step();
    chk("stall_f2_n", got2.size(), 1);
    chk("stall_f2_0", got2[0], 32'hCC);
    chk("stall_f1_n", got1.size(), 0);

    // Drain with 0xDD held and both full.
    clear_logs();
    fifo2_full = 1'b1;
    send(32'hDD);
    in_valid = 1'b0;
    drain    = 1'b1;
    step(); step();
    chk("drain_in_ready", in_ready, 0);
    chk("drain_not_done", drain_done, 0);
    fifo1_full = 1'b0;
    #1;
    chk("drain_wr1", fifo1_wr, 1);
    chk("drain_data1", fifo1_data, 32'hDD);
    step();
    chk("drain_done", drain_done, 1);
    chk("drain_ready_blocked", in_ready, 0);
    drain      = 1'b0;
    fifo2_full = 1'b0;
    step();
    chk("drain_release", drain_done, 0);
    chk("drain_f1_n", got1.size(), 1);

    // Reset while 0xEE is held and both FIFOs are full.
    clear_logs();
    fifo1_full = 1'b1;
    fifo2_full = 1'b1;
    send(32'hEE);
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_wr1", fifo1_wr, 0);
    chk("mid_rst_wr2", fifo2_wr, 0);
    chk("mid_rst_data2", fifo2_data, 0);
    chk("mid_rst_drain_done", drain_done, 0);
`ifdef DISPATCH_STATS_EN
    chk("mid_rst_cnt1", disp_cnt1, 0);
    chk("mid_rst_stall", stall_cnt, 0);
`endif
    fifo1_full = 1'b0;
    fifo2_full = 1'b0;
    repeat (3) step();
    chk("mid_rst_no_writes", got1.size() + got2.size(), 0);

    // 2^CNT_W+3 dispatches all forced into FIFO1; order and saturation.
    clear_logs();
    fifo2_full = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) send(32'h100 + i);
    in_valid = 1'b0;
    step(); step();
    chk("sat_f1_n", got1.size(), (1 << CNT_W) + 3);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) chk("sat_order", got1[i], 32'h100 + i);
`ifdef DISPATCH_STATS_EN
    chk("sat_cnt1", disp_cnt1, CMAX);
    chk("sat_cnt2", disp_cnt2, 0);
`endif
    fifo2_full = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
